// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and byte-lane helpers for the Ethernet header strip stage
package eth_pkg;

  localparam int          ETH_HDR_BYTES = 14;
  localparam logic [47:0] MAC_BCAST     = 48'hffffffffffff;

  typedef enum logic [2:0] {HDR0, HDR1, BODY, FLUSH, DROP} eth_strip_state_t;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
  } eth_hdr_t;

  function automatic logic [3:0] keep_count(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
    return n;
  endfunction

  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (4'(i) < n);
    return m;
  endfunction

  function automatic logic [63:0] mask_bytes(input logic [63:0] data, input logic [7:0] keep);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
    return d;
  endfunction

endpackage

// File: rtl/eth_axis_out_reg.sv
// rtl/eth_axis_out_reg.sv - registered DATA/KEEP/LAST/VALID output stage, loads when empty or drained
module eth_axis_out_reg (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        push,
  input  logic [63:0] beat_data,
  input  logic [7:0]  beat_keep,
  input  logic        beat_last,
  input  logic        ready,
  output logic        load,
  output logic [63:0] data,
  output logic [7:0]  keep,
  output logic        last,
  output logic        valid
);

  assign load = !valid || ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      valid <= push;
      if (push) begin
        data <= beat_data;
        keep <= beat_keep;
        last <= beat_last;
      end
    end
  end

endmodule

// File: rtl/eth_header_strip.sv
// rtl/eth_header_strip.sv - MAC filter, header capture and 6-byte payload realignment for 64-bit rx stream
// Optional saturating frame counters when ETH_HEADER_STRIP_STATS_EN is defined.
module eth_header_strip
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] stream_in_DATA,
  input  logic [7:0]  stream_in_KEEP,
  input  logic        stream_in_LAST,
  input  logic        stream_in_VALID,
  output logic        stream_in_READY,
  output logic [63:0] stream_out_DATA,
  output logic [7:0]  stream_out_KEEP,
  output logic        stream_out_LAST,
  output logic        stream_out_VALID,
  input  logic        stream_out_READY,
  output logic [47:0] hdr_mac_dst,
  output logic [47:0] hdr_mac_src,
  output logic [15:0] hdr_ethertype,
  output logic        hdr_valid
`ifdef ETH_HEADER_STRIP_STATS_EN
  ,
  output logic [31:0] stat_rx_frames,
  output logic [31:0] stat_drop_mac,
  output logic [31:0] stat_drop_runt
`endif
);

  // Header bytes carried in the second flit; the remainder becomes the residual shift.
  localparam int HDR1_TAIL = ETH_HDR_BYTES - 8;

  eth_strip_state_t state;
  eth_hdr_t         hdr;
  logic [15:0]      res;
  logic             flush_two;
  logic [3:0]       n;
  logic [47:0]      wire_dst;
  logic             mac_ok, out_load, take, push, beat_last, short_last;
  logic [63:0]      beat_data, beat_masked;
  logic [7:0]       beat_keep;

  assign n          = keep_count(stream_in_KEEP);
  assign wire_dst   = {stream_in_DATA[7:0],   stream_in_DATA[15:8],  stream_in_DATA[23:16],
                       stream_in_DATA[31:24], stream_in_DATA[39:32], stream_in_DATA[47:40]};
  assign mac_ok     = (wire_dst == MAC_ADDR_FPGA) || (wire_dst == MAC_BCAST);
  assign short_last = stream_in_LAST && (n <= 4'(HDR1_TAIL));

  assign stream_in_READY = (state == DROP) || ((state != FLUSH) && out_load);
  assign take            = stream_in_VALID && stream_in_READY;

  always_comb begin
    push      = 1'b0;
    beat_data = '0;
    beat_keep = '0;
    beat_last = 1'b0;
    case (state)
      HDR1: if (take && stream_in_LAST && !short_last) begin
        push      = 1'b1;
        beat_data = {48'h0, stream_in_DATA[63:48]};
        beat_keep = keep_mask(n - 4'(HDR1_TAIL));
        beat_last = 1'b1;
      end
      BODY: if (take) begin
        push      = 1'b1;
        beat_data = {stream_in_DATA[47:0], res};
        beat_keep = 8'hff;
        if (short_last) begin
          beat_keep = keep_mask(n + 4'd2);
          beat_last = 1'b1;
        end
      end
      FLUSH: if (out_load) begin
        push      = 1'b1;
        beat_data = {48'h0, res};
        beat_keep = keep_mask(flush_two ? 4'd2 : 4'd1);
        beat_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign beat_masked = mask_bytes(beat_data, beat_keep);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= HDR0;
      hdr       <= '0;
      res       <= '0;
      flush_two <= 1'b0;
      hdr_valid <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      case (state)
        HDR0: if (take) begin
          hdr.dst        <= wire_dst;
          hdr.src[47:32] <= {stream_in_DATA[55:48], stream_in_DATA[63:56]};
          if (stream_in_LAST) state <= HDR0;
          else if (mac_ok)    state <= HDR1;
          else                state <= DROP;
        end
        HDR1: if (take) begin
          hdr.src[31:0]  <= {stream_in_DATA[7:0], stream_in_DATA[15:8],
                             stream_in_DATA[23:16], stream_in_DATA[31:24]};
          hdr.ethertype  <= {stream_in_DATA[39:32], stream_in_DATA[47:40]};
          hdr_valid      <= 1'b1;
          res            <= stream_in_DATA[63:48];
          state          <= stream_in_LAST ? HDR0 : BODY;
        end
        BODY: if (take) begin
          res <= stream_in_DATA[63:48];
          if (stream_in_LAST) begin
            flush_two <= (n == 4'd8);
            state     <= short_last ? HDR0 : FLUSH;
          end
        end
        FLUSH: if (out_load) state <= HDR0;
        DROP:  if (take && stream_in_LAST) state <= HDR0;
        default: state <= HDR0;
      endcase
    end
  end

  assign hdr_mac_dst   = hdr.dst;
  assign hdr_mac_src   = hdr.src;
  assign hdr_ethertype = hdr.ethertype;

  eth_axis_out_reg u_out (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .beat_data (beat_masked),
    .beat_keep (beat_keep),
    .beat_last (beat_last),
    .ready     (stream_out_READY),
    .load      (out_load),
    .data      (stream_out_DATA),
    .keep      (stream_out_KEEP),
    .last      (stream_out_LAST),
    .valid     (stream_out_VALID)
  );

`ifdef ETH_HEADER_STRIP_STATS_EN
  logic ev_rx, ev_mac, ev_runt;

  assign ev_runt = take && (((state == HDR0) && stream_in_LAST) || ((state == HDR1) && short_last));
  assign ev_mac  = take && (state == HDR0) && !stream_in_LAST && !mac_ok;
  assign ev_rx   = take && (state == HDR1) && !short_last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_rx_frames <= '0;
      stat_drop_mac  <= '0;
      stat_drop_runt <= '0;
    end else begin
      if (ev_rx && (stat_rx_frames != '1))   stat_rx_frames <= stat_rx_frames + 32'd1;
      if (ev_mac && (stat_drop_mac != '1))   stat_drop_mac  <= stat_drop_mac + 32'd1;
      if (ev_runt && (stat_drop_runt != '1)) stat_drop_runt <= stat_drop_runt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_header_strip.sv
// tb/tb_eth_header_strip.sv - self-checking bench for eth_header_strip (frame tables, random frames, reset)
module tb_eth_header_strip;

  localparam logic [47:0] MAC_OK  = 48'hfa163e55ca02;
  localparam logic [47:0] MAC_BC  = 48'hffffffffffff;
  localparam logic [47:0] MAC_BAD = 48'h0cc47a88c047;

  typedef struct {
    int         len;
    int         dst_sel;
    int         exp_beats;
    logic [7:0] exp_last_keep;
    int         exp_stalls;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_last, out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] hdr_mac_dst, hdr_mac_src;
  logic [15:0] hdr_ethertype;
  logic        hdr_valid;
`ifdef ETH_HEADER_STRIP_STATS_EN
  logic [31:0] stat_rx_frames, stat_drop_mac, stat_drop_runt;
`endif

  int tests = 0;
  int fails = 0;

  bit           rand_ready = 1'b0;
  byte unsigned frame[$];
  byte unsigned cur_bytes[$];
  byte unsigned got_bytes[$];
  byte unsigned exp_bytes[$];
  int           got_lens[$];
  int           exp_lens[$];
  int           win_beats = 0;
  logic [7:0]   win_last_keep = '0;
  int           stall_cycles = 0;
  int           hdr_pulses = 0;
  logic [7:0]   mon_kp1;
  bit           mon_ok;

  always #5 aclk = ~aclk;

  eth_header_strip dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .stream_in_DATA   (in_data),
    .stream_in_KEEP   (in_keep),
    .stream_in_LAST   (in_last),
    .stream_in_VALID  (in_valid),
    .stream_in_READY  (in_ready),
    .stream_out_DATA  (out_data),
    .stream_out_KEEP  (out_keep),
    .stream_out_LAST  (out_last),
    .stream_out_VALID (out_valid),
    .stream_out_READY (out_ready),
    .hdr_mac_dst      (hdr_mac_dst),
    .hdr_mac_src      (hdr_mac_src),
    .hdr_ethertype    (hdr_ethertype),
    .hdr_valid        (hdr_valid)
`ifdef ETH_HEADER_STRIP_STATS_EN
    ,
    .stat_rx_frames   (stat_rx_frames),
    .stat_drop_mac    (stat_drop_mac),
    .stat_drop_runt   (stat_drop_runt)
`endif
  );

  // Output monitor: drives downstream ready, records beats that will transfer on the next edge.
  always @(negedge aclk) begin
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (aresetn) begin
      if (!in_ready) stall_cycles++;
      if (hdr_valid) hdr_pulses++;
      if (out_valid && out_ready) begin
        mon_kp1 = out_keep + 8'd1;
        mon_ok  = (out_keep != 8'h00) && ((out_keep & mon_kp1) == 8'h00) &&
                  (out_last || (out_keep == 8'hff));
        for (int k = 0; k < 8; k++)
          if (!out_keep[k] && (out_data[8*k +: 8] != 8'h00)) mon_ok = 1'b0;
        tests++;
        if (!mon_ok) begin
          fails++;
          $display("FAIL beat_form: keep=%h last=%b data=%h, required contiguous keep (ff unless last) and zero unused lanes",
                   out_keep, out_last, out_data);
        end
        for (int k = 0; k < 8; k++)
          if (out_keep[k]) cur_bytes.push_back(out_data[8*k +: 8]);
        win_beats++;
        if (out_last) begin
          win_last_keep = out_keep;
          got_lens.push_back(cur_bytes.size());
          foreach (cur_bytes[j]) got_bytes.push_back(cur_bytes[j]);
          cur_bytes.delete();
        end
      end
    end
  end

  task automatic check_int(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_payload(input string name);
    int bad;
    bad = -1;
    if (got_bytes.size() == exp_bytes.size())
      for (int i = 0; i < exp_bytes.size(); i++)
        if (bad < 0 && got_bytes[i] != exp_bytes[i]) bad = i;
    tests++;
    if (got_bytes.size() != exp_bytes.size() || bad >= 0) begin
      fails++;
      $display("FAIL %s: got %0d payload bytes (first diff at %0d), expected %0d bytes",
               name, got_bytes.size(), bad, exp_bytes.size());
    end
  endtask

  task automatic check_lens(input string name);
    int bad;
    bad = (got_lens.size() == exp_lens.size()) ? -1 : 0;
    if (bad < 0)
      for (int i = 0; i < exp_lens.size(); i++)
        if (bad < 0 && got_lens[i] != exp_lens[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: got %0d frames, expected %0d frames (first length diff at %0d)",
               name, got_lens.size(), exp_lens.size(), bad);
    end
  endtask

  task automatic clear_mon();
    got_bytes.delete();
    got_lens.delete();
    exp_bytes.delete();
    exp_lens.delete();
    cur_bytes.delete();
    win_beats     = 0;
    win_last_keep = '0;
    stall_cycles  = 0;
    hdr_pulses    = 0;
  endtask

  task automatic build_frame(input int len, input logic [47:0] dst);
    logic [47:0] src;
    src = MAC_BAD;
    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame.push_back(src[47-8*i -: 8]);
    frame.push_back(8'h08);
    frame.push_back(8'h00);
    for (int i = 14; i < len; i++) frame.push_back(8'($urandom_range(0, 255)));
    while (frame.size() > len) void'(frame.pop_back());
  endtask

  // Reference: an accepted frame longer than the header yields exactly bytes 14..len-1.
  task automatic model_frame(input logic [47:0] dst);
    if (frame.size() > 14 && (dst == MAC_OK || dst == MAC_BC)) begin
      exp_lens.push_back(frame.size() - 14);
      for (int i = 14; i < frame.size(); i++) exp_bytes.push_back(frame[i]);
    end
  endtask

  task automatic send_flit(input logic [63:0] d, input logic [7:0] k, input logic l);
    int g;
    g = 0;
    @(negedge aclk);
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    #2;
    while (!in_ready && g < 2000) begin
      @(negedge aclk);
      #2;
      g++;
    end
    if (g >= 2000) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: ready stayed 0 for %0d cycles, required 1", g);
    end
    @(posedge aclk);
  endtask

  task automatic send_frame(input int max_flits, input bit gaps);
    int len;
    int nfl;
    logic [63:0] d;
    logic [7:0]  k;
    len = frame.size();
    nfl = 0;
    for (int off = 0; off < len && nfl < max_flits; off += 8) begin
      for (int b = 0; b < 8; b++) begin
        k[b]         = (off + b < len);
        d[8*b +: 8]  = (off + b < len) ? frame[off + b] : 8'($urandom_range(0, 255));
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge aclk);
        in_valid = 1'b0;
      end
      send_flit(d, k, (off + 8 >= len));
      nfl++;
    end
  endtask

  task automatic idle(input int cycles);
    @(negedge aclk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(negedge aclk);
  endtask

  task automatic wait_frames(input int n, input string name);
    int g;
    g = 0;
    while (got_lens.size() < n && g < 40000) begin
      @(negedge aclk);
      g++;
    end
    check_int(name, got_lens.size(), n);
  endtask

  initial begin
    vec_t        vecs[14];
    logic [47:0] dst;
    int          nrx, nmac, nrunt;

    vecs[0]  = '{60, 0, 6, 8'h3f, 0};
    vecs[1]  = '{64, 2, 0, 8'h00, 0};
    vecs[2]  = '{15, 0, 1, 8'h01, 0};
    vecs[3]  = '{24, 0, 2, 8'h03, 1};
    vecs[4]  = '{10, 0, 0, 8'h00, 0};
    vecs[5]  = '{14, 0, 0, 8'h00, 0};
    vecs[6]  = '{16, 1, 1, 8'h03, 0};
    vecs[7]  = '{17, 0, 1, 8'h07, 0};
    vecs[8]  = '{21, 1, 1, 8'h7f, 0};
    vecs[9]  = '{22, 0, 1, 8'hff, 0};
    vecs[10] = '{23, 0, 2, 8'h01, 1};
    vecs[11] = '{30, 0, 2, 8'hff, 0};
    vecs[12] = '{8,  2, 0, 8'h00, 0};
    vecs[13] = '{9,  0, 0, 8'h00, 0};
    nrx = 0; nmac = 0; nrunt = 0;

    repeat (3) @(negedge aclk);
    #1;
    check_int("reset_outputs",
              {out_valid, out_last, out_keep, out_data, hdr_valid, hdr_mac_dst, hdr_mac_src, hdr_ethertype}, 0);
`ifdef ETH_HEADER_STRIP_STATS_EN
    check_int("reset_stats", {stat_rx_frames, stat_drop_mac, stat_drop_runt}, 0);
`endif
    @(negedge aclk);
    aresetn = 1'b1;
    idle(2);

    rand_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      dst = (vecs[i].dst_sel == 0) ? MAC_OK : (vecs[i].dst_sel == 1) ? MAC_BC : MAC_BAD;
      clear_mon();
      build_frame(vecs[i].len, dst);
      if (vecs[i].len == 15) frame[14] = 8'h5a;
      model_frame(dst);
      if (vecs[i].len <= 14) nrunt++;
      else if (vecs[i].dst_sel == 2) nmac++;
      else nrx++;
      send_frame(1000, 1'b0);
      idle(8);
      check_int($sformatf("v%0d_beats", i), win_beats, vecs[i].exp_beats);
      check_int($sformatf("v%0d_last_keep", i), win_last_keep, vecs[i].exp_last_keep);
      check_int($sformatf("v%0d_in_stalls", i), stall_cycles, vecs[i].exp_stalls);
      check_lens($sformatf("v%0d_frames", i));
      check_payload($sformatf("v%0d_payload", i));
      if (i == 0) begin
        check_int("hdr_ethertype", hdr_ethertype, 16'h0800);
        check_int("hdr_mac_dst", hdr_mac_dst, MAC_OK);
        check_int("hdr_mac_src", hdr_mac_src, MAC_BAD);
        check_int("hdr_valid_pulses", hdr_pulses, 1);
      end
    end
`ifdef ETH_HEADER_STRIP_STATS_EN
    check_int("stat_rx_frames", stat_rx_frames, nrx);
    check_int("stat_drop_mac", stat_drop_mac, nmac);
    check_int("stat_drop_runt", stat_drop_runt, nrunt);
`endif

    clear_mon();
    build_frame(60, MAC_OK);
    model_frame(MAC_OK);
    send_frame(1000, 1'b0);
    build_frame(23, MAC_BC);
    model_frame(MAC_BC);
    send_frame(1000, 1'b0);
    idle(8);
    wait_frames(2, "b2b_frames");
    check_lens("b2b_lens");
    check_payload("b2b_payload");
    check_int("b2b_in_stalls", stall_cycles, 1);

    clear_mon();
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      build_frame($urandom_range(60, 1514), MAC_BC);
      model_frame(MAC_BC);
      send_frame(1000, 1'b1);
    end
    idle(4);
    wait_frames(30, "rand_frames");
    check_lens("rand_lens");
    check_payload("rand_payload");

    rand_ready = 1'b0;
    clear_mon();
    build_frame(200, MAC_BC);
    send_frame(5, 1'b0);
    @(negedge aclk);
    aresetn  = 1'b0;
    in_valid = 1'b0;
    #1;
    check_int("midreset_outputs",
              {out_valid, out_last, out_keep, out_data, hdr_valid, hdr_mac_dst, hdr_mac_src, hdr_ethertype}, 0);
`ifdef ETH_HEADER_STRIP_STATS_EN
    check_int("midreset_stats", {stat_rx_frames, stat_drop_mac, stat_drop_runt}, 0);
`endif
    repeat (2) @(negedge aclk);
    clear_mon();
    aresetn = 1'b1;
    idle(2);
    build_frame(60, MAC_OK);
    model_frame(MAC_OK);
    send_frame(1000, 1'b0);
    idle(8);
    wait_frames(1, "post_reset_frames");
    check_lens("post_reset_lens");
    check_payload("post_reset_payload");
    check_int("post_reset_ethertype", hdr_ethertype, 16'h0800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
